mips_run_controller: RTL and testbench

- Synthesizable run/debug controller for the single-cycle MIPS core; generalises the bench-side stop-at-PC and dump loop.
- Gates the core's per-instruction enable and counts executed instructions.
- Halts on end-PC, PC limit, any of NUM_BP breakpoints, or a cycle budget, and supports single-step mode.
- After every halt, streams the full register file out over a valid/ready port.

---
 rtl/mips_run_controller_if.sv | 24 ++
 rtl/mips_run_controller.sv | 187 ++++++++++++++++++
 tb/tb_mips_run_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_controller_if.sv
// Register-file read port and register-dump stream of the MIPS run controller.
// master = controller side, slave = register file / dump consumer side.
interface mips_run_controller_if #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);
  logic              reg_rd_en;
  logic [REG_AW-1:0] reg_addr;
  logic [DATA_W-1:0] reg_rdata;
  logic [DATA_W-1:0] dump_data;
  logic [REG_AW-1:0] dump_idx;
  logic              dump_valid;
  logic              dump_ready;

  modport master (
    output reg_rd_en, reg_addr, dump_data, dump_idx, dump_valid,
    input  reg_rdata, dump_ready
  );

  modport slave (
    input  reg_rd_en, reg_addr, dump_data, dump_idx, dump_valid,
    output reg_rdata, dump_ready
  );
endinterface

// File: rtl/mips_run_controller.sv
// Run/debug controller for the single-cycle MIPS core: gates the per-instruction
// enable, counts executed instructions, halts on end-PC / PC limit / breakpoint /
// instruction budget, supports single-step, and streams the register file out
// over a valid/ready port after every halt.
module mips_run_controller #(
  parameter int PC_W     = 32,
  parameter int PC_LIMIT = 1024,
  parameter int NUM_BP   = 4,
  parameter int CYC_W    = 16,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                   LOOP,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   step,
  input  logic                   step_mode,
  input  logic [PC_W-1:0]        halt_pc,
  input  logic [NUM_BP*PC_W-1:0] bp_pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [CYC_W-1:0]       max_cycles,
  input  logic [PC_W-1:0]        pc,
  output logic                   cpu_en,
  mips_run_controller_if.master  rf,
  output logic [CYC_W-1:0]       cycle_count,
  output logic [1:0]             halt_cause,
  output logic [2:0]             state,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PAUSE    = 3'd2,
    DUMP_REQ = 3'd3,
    DUMP_OUT = 3'd4,
    DONE     = 3'd5
  } ctrlState_e;

  localparam logic [PC_W-1:0]   PC_LIM_V  = PC_W'(PC_LIMIT);
  localparam logic [REG_AW-1:0] LAST_IDX  = '1;
  localparam logic [1:0]        CAUSE_END = 2'd1;
  localparam logic [1:0]        CAUSE_BP  = 2'd2;
  localparam logic [1:0]        CAUSE_TO  = 2'd3;

  ctrlState_e        stateQ, stateNext;
  logic              bpSkip;
  logic [REG_AW-1:0] dumpIndex;
  logic              regRdEn;
  logic              cpuEnRaw;

  logic              endHit, bpHit, toHit, hit;
  logic [1:0]        hitCause;

  // dump output stage registers
  logic [DATA_W-1:0] dumpData_p1;
  logic [REG_AW-1:0] dumpIdx_p1;
  logic              vld_p1;

  // Saturating increment of the executed-instruction counter.
  function automatic logic [CYC_W-1:0] satInc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Halt detection on the current PC, priority end > breakpoint > budget.
  always_comb begin
    endHit = (pc == halt_pc) || (pc >= PC_LIM_V);
    bpHit  = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (pc == bp_pc[i*PC_W +: PC_W])) bpHit = 1'b1;
    end
    // A resumed breakpoint must not re-trigger on the instruction it stopped at.
    bpHit  = bpHit && !bpSkip;
    toHit  = (max_cycles != '0) && (cycle_count == max_cycles);
    hit    = endHit || bpHit || toHit;
    if (endHit)     hitCause = CAUSE_END;
    else if (bpHit) hitCause = CAUSE_BP;
    else if (toHit) hitCause = CAUSE_TO;
    else            hitCause = 2'd0;
  end

  // Next-state and core-enable decode.
  always_comb begin
    stateNext = stateQ;
    cpuEnRaw  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start) stateNext = step_mode ? PAUSE : RUN;
      end
      RUN: begin
        if (hit) stateNext = DUMP_REQ;
        else     cpuEnRaw  = 1'b1;
      end
      PAUSE: begin
        if (step) begin
          if (hit) stateNext = DUMP_REQ;
          else     cpuEnRaw  = 1'b1;
        end
      end
      DUMP_REQ: begin
        stateNext = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (vld_p1 && rf.dump_ready) stateNext = (dumpIndex == LAST_IDX) ? DONE : DUMP_REQ;
      end
      DONE: begin
        if (start) stateNext = step_mode ? PAUSE : RUN;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The core never steps while reset is held, whatever state is registered.
  assign cpu_en = cpuEnRaw && !RESET;

  // Control registers: state, counter, halt cause, dump sequencing.
  always_ff @(posedge LOOP) begin
    if (RESET) begin
      stateQ      <= IDLE;
      cycle_count <= '0;
      halt_cause  <= 2'd0;
      vld_p1      <= 1'b0;
      regRdEn     <= 1'b0;
      done        <= 1'b0;
      bpSkip      <= 1'b0;
      dumpIndex   <= '0;
    end else begin
      stateQ  <= stateNext;
      regRdEn <= (stateNext == DUMP_REQ);
      done    <= (stateNext == DONE);
      if (cpu_en) cycle_count <= satInc(cycle_count);
      case (stateQ)
        IDLE: begin
          cycle_count <= '0;
          halt_cause  <= 2'd0;
          bpSkip      <= 1'b0;
        end
        RUN, PAUSE: begin
          if ((stateQ == RUN) || step) bpSkip <= 1'b0;
          if (stateNext == DUMP_REQ) begin
            halt_cause <= hitCause;
            dumpIndex  <= '0;
          end
        end
        DUMP_OUT: begin
          if (!vld_p1) begin
            vld_p1 <= 1'b1;
          end else if (rf.dump_ready) begin
            vld_p1    <= 1'b0;
            dumpIndex <= dumpIndex + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            halt_cause <= 2'd0;
            if (halt_cause == CAUSE_BP) begin
              bpSkip <= 1'b1;
            end else begin
              cycle_count <= '0;
              bpSkip      <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---- stage p1: capture register-file data one cycle after the read ----
  always_ff @(posedge LOOP) begin
    if ((stateQ == DUMP_OUT) && !vld_p1) begin
      dumpData_p1 <= rf.reg_rdata;
      dumpIdx_p1  <= dumpIndex;
    end
  end

  assign rf.reg_rd_en  = regRdEn;
  assign rf.reg_addr   = dumpIndex;
  assign rf.dump_data  = dumpData_p1;
  assign rf.dump_idx   = dumpIdx_p1;
  assign rf.dump_valid = vld_p1;
  assign state         = stateQ;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller with a PC-incrementing core model and
// a registered-read register file model.
module tb_mips_run_controller;
  localparam int PC_W   = 32;
  localparam int NUM_BP = 4;
  localparam int CYC_W  = 16;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  logic                   LOOP;
  logic                   RESET;
  logic                   start, step, step_mode;
  logic [PC_W-1:0]        halt_pc;
  logic [NUM_BP*PC_W-1:0] bp_pc;
  logic [NUM_BP-1:0]      bp_en;
  logic [CYC_W-1:0]       max_cycles;
  logic [PC_W-1:0]        pc;
  logic                   cpu_en;
  logic [CYC_W-1:0]       cycle_count;
  logic [1:0]             halt_cause;
  logic [2:0]             state;
  logic                   done;
  logic                   coreRst;
  logic [DATA_W-1:0]      rfMem [2**REG_AW];

  int nAssert = 0;
  int nFail   = 0;

  mips_run_controller_if #(.REG_AW(REG_AW), .DATA_W(DATA_W)) rf ();

  mips_run_controller #(
    .PC_W(PC_W), .PC_LIMIT(1024), .NUM_BP(NUM_BP),
    .CYC_W(CYC_W), .REG_AW(REG_AW), .DATA_W(DATA_W)
  ) dut (
    .LOOP(LOOP), .RESET(RESET), .start(start), .step(step), .step_mode(step_mode),
    .halt_pc(halt_pc), .bp_pc(bp_pc), .bp_en(bp_en), .max_cycles(max_cycles),
    .pc(pc), .cpu_en(cpu_en), .rf(rf), .cycle_count(cycle_count),
    .halt_cause(halt_cause), .state(state), .done(done)
  );

  initial LOOP = 1'b0;
  always #5 LOOP = ~LOOP;

  // Core model: PC advances by 4 on each enabled instruction.
  always @(posedge LOOP) begin
    if (coreRst)     pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  // Register file model: data valid the cycle after the read request.
  always @(posedge LOOP) begin
    if (rf.reg_rd_en) rf.reg_rdata <= rfMem[rf.reg_addr];
  end

  function automatic logic [DATA_W-1:0] regVal(input int i);
    return 32'hC0DE_0000 + i * 32'h0001_0203;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic startRun(input bit resetCore);
    coreRst = resetCore;
    start   = 1'b1;
    @(negedge LOOP);
    coreRst = 1'b0;
    start   = 1'b0;
  endtask

  // Runs until done, counting enabled cycles and checking every dump beat.
  task automatic runDump(input int holdIdx, input int rstIdx,
                         output int enCount, output int beats, output bit aborted);
    int hold = 0;
    bit holding = 0;
    logic [DATA_W-1:0] heldData = '0;
    enCount = 0;
    beats   = 0;
    aborted = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) break;
      if (cpu_en) enCount++;
      if (holding) begin
        check("hold_valid", rf.dump_valid, 1);
        check("hold_idx",   rf.dump_idx, holdIdx);
        check("hold_data",  rf.dump_data, heldData);
      end
      if (rf.dump_valid && (int'(rf.dump_idx) == rstIdx)) begin
        RESET = 1'b1;
        @(negedge LOOP);
        RESET = 1'b0;
        check("rst_state", state, 0);
        check("rst_valid", rf.dump_valid, 0);
        check("rst_done",  done, 0);
        check("rst_count", cycle_count, 0);
        aborted = 1;
        return;
      end
      if (rf.dump_valid) begin
        if ((int'(rf.dump_idx) == holdIdx) && (hold < 10)) begin
          if (hold == 0) heldData = rf.dump_data;
          holding = 1;
          rf.dump_ready = 1'b0;
          hold++;
        end else begin
          rf.dump_ready = 1'b1;
          check("beat_idx",  rf.dump_idx, beats);
          check("beat_data", rf.dump_data, regVal(beats));
          if (int'(rf.dump_idx) == holdIdx) holding = 0;
          beats++;
        end
      end else begin
        rf.dump_ready = 1'b1;
      end
      @(negedge LOOP);
    end
    check("reached_done", done, 1);
  endtask

  initial begin
    int en, beats, pulses;
    bit ab;
    for (int i = 0; i < 2**REG_AW; i++) rfMem[i] = regVal(i);
    RESET = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0;
    halt_pc = 32'd84; bp_pc = '0; bp_en = '0; max_cycles = '0;
    coreRst = 1'b1; rf.dump_ready = 1'b1;
    repeat (3) @(negedge LOOP);
    check("rst_state0", state, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_count0", cycle_count, 0);
    check("rst_cause0", halt_cause, 0);
    check("rst_dvalid", rf.dump_valid, 0);
    check("rst_rd_en",  rf.reg_rd_en, 0);
    check("rst_done0",  done, 0);
    RESET = 1'b0; coreRst = 1'b0;
    @(negedge LOOP);

    // free run to PC 84 with backpressure on beat 7
    startRun(1);
    runDump(7, -1, en, beats, ab);
    check("free_en",    en, 21);
    check("free_count", cycle_count, 21);
    check("free_cause", halt_cause, 1);
    check("free_beats", beats, 32);
    check("free_state", state, 5);

    // breakpoint at 40, then resume to 84
    bp_pc[1*PC_W +: PC_W] = 32'd40;
    bp_en = 4'b0010;
    startRun(1);
    runDump(-1, -1, en, beats, ab);
    check("bp_en_cnt", en, 10);
    check("bp_count",  cycle_count, 10);
    check("bp_cause",  halt_cause, 2);
    check("bp_pc",     pc, 40);
    startRun(0);
    runDump(-1, -1, en, beats, ab);
    check("res_en_cnt", en, 11);
    check("res_count",  cycle_count, 21);
    check("res_cause",  halt_cause, 1);
    check("res_beats",  beats, 32);

    // instruction budget
    bp_en = '0;
    max_cycles = 16'd5;
    startRun(1);
    runDump(-1, -1, en, beats, ab);
    check("to_en_cnt", en, 5);
    check("to_count",  cycle_count, 5);
    check("to_cause",  halt_cause, 3);

    // single-step: three pulses, then a step onto the halting PC
    max_cycles = '0;
    halt_pc = 32'd12;
    step_mode = 1'b1;
    startRun(1);
    check("step_pause", state, 2);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step = ((c % 4) == 1);
      #1;
      check("step_cpu_en", cpu_en, step);
      if (cpu_en) pulses++;
      @(negedge LOOP);
    end
    step = 1'b0;
    check("step_pulses", pulses, 3);
    check("step_count",  cycle_count, 3);
    step = 1'b1;
    #1;
    check("step_at_halt", cpu_en, 0);
    @(negedge LOOP);
    step = 1'b0;
    check("step_dumpreq", state, 3);
    check("step_rd_en",   rf.reg_rd_en, 1);
    check("step_addr",    rf.reg_addr, 0);
    runDump(-1, -1, en, beats, ab);
    check("step_cause", halt_cause, 1);
    check("step_cnt2",  cycle_count, 3);
    check("step_beats", beats, 32);

    // reset in the middle of the dump, then a clean re-run
    step_mode = 1'b0;
    halt_pc = 32'd84;
    startRun(1);
    runDump(-1, 12, en, beats, ab);
    check("rst_aborted", ab, 1);
    check("rst_beats",   beats, 12);
    startRun(1);
    runDump(-1, -1, en, beats, ab);
    check("rerun_en",    en, 21);
    check("rerun_count", cycle_count, 21);
    check("rerun_beats", beats, 32);

    // PC limit, enabled breakpoint and exhausted budget at the same PC
    halt_pc = 32'd2000;
    bp_pc[0 +: PC_W] = 32'd1024;
    bp_en = 4'b0001;
    max_cycles = 16'd256;
    startRun(1);
    runDump(-1, -1, en, beats, ab);
    check("prio_en",    en, 256);
    check("prio_count", cycle_count, 256);
    check("prio_cause", halt_cause, 1);

    // start and reset together: reset wins
    RESET = 1'b1;
    start = 1'b1;
    @(negedge LOOP);
    RESET = 1'b0;
    start = 1'b0;
    check("rs_state", state, 0);
    check("rs_done",  done, 0);
    check("rs_count", cycle_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
